serial_adder_ctrl: RTL

Bit-serial multi-bit adder controller. It time-shares one instance of the existing 1-bit full_adder cell across WIDTH cycles, processing one bit per clock. It sequences the operand shift registers and the carry flip-flop, and presents a start/busy/done handshake to the upstream requester. It is the first sequential block built on the combinational adder library.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder library: FSM state encodings and default width.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell from the combinational adder library.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder processes one operand bit per clock,
// LSB first, with a start/busy/done handshake towards the requester.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh, a_sh_d;
    logic [WIDTH-1:0]   b_sh, b_sh_d;
    logic [WIDTH-1:0]   s_sh, s_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d;
    logic               fa_sum;
    logic               fa_carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next-state, datapath sequencing and handshake outputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh;
        b_sh_d  = b_sh;
        s_sh_d  = s_sh;
        carry_d = carry_q;
        cnt_d   = cnt;
        sum_d   = sum_out;
        cout_d  = cout;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                a_sh_d  = a_sh >> 1;
                b_sh_d  = b_sh >> 1;
                s_sh_d  = {fa_sum, s_sh[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish the completed word directly from the adder.
                    sum_d   = {fa_sum, s_sh[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh    <= a_sh_d;
            b_sh    <= b_sh_d;
            s_sh    <= s_sh_d;
            carry_q <= carry_d;
            cnt     <= cnt_d;
            sum_out <= sum_d;
            cout    <= cout_d;
        end
    end

endmodule
